io_output_buffer: RTL and testbench

//   Buffered, flow-controlled successor to the simulation-only CPU output port.

---
 rtl/io_output_buffer.sv | 132 +++++++++++++
 tb/tb_io_output_buffer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/io_output_buffer.sv
// CPU output port buffer: a FIFO of bytes written by the core, drained over a
// valid/ready byte stream, with optional LF -> CR,LF expansion.
module io_output_buffer #(
    parameter int WORD_SIZE  = 16,
    parameter int BYTE_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int NL_EXPAND  = 0
) (
    input  logic                     clk,
    input  logic                     areset,
    input  logic                     out_write,
    input  logic [WORD_SIZE-1:0]     io_out,
    output logic                     out_ready,
    output logic                     out_overflow,
    input  logic                     out_clear,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic                     tx_valid,
    output logic [BYTE_WIDTH-1:0]    tx_data,
    input  logic                     tx_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [BYTE_WIDTH-1:0] CHAR_LF = BYTE_WIDTH'(8'h0A);
    localparam logic [BYTE_WIDTH-1:0] CHAR_CR = BYTE_WIDTH'(8'h0D);

    if (NL_EXPAND != 0 && BYTE_WIDTH < 8) begin : gBadExpand
        $error("io_output_buffer: NL_EXPAND requires BYTE_WIDTH >= 8");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gBadDepth
        $error("io_output_buffer: DEPTH must be a power of two >= 2");
    end
    if (WORD_SIZE < BYTE_WIDTH) begin : gBadWord
        $error("io_output_buffer: WORD_SIZE must be >= BYTE_WIDTH");
    end

    typedef enum logic {
        S_DATA,
        S_LF
    } drainState_e;

    drainState_e           state_q, state_d;
    logic [AW:0]           wrPtr_q, wrPtr_d;
    logic [AW:0]           rdPtr_q, rdPtr_d;
    logic                  overflow_q, overflow_d;
    logic [BYTE_WIDTH-1:0] mem [DEPTH];

    logic                  empty;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  headIsLf;
    logic [BYTE_WIDTH-1:0] head;
    logic                  unusedIoBits;

    // Only the low byte of the CPU word is stored.
    assign unusedIoBits = ^io_out;

    assign empty    = (wrPtr_q == rdPtr_q);
    assign full     = ((wrPtr_q ^ rdPtr_q) == {1'b1, {AW{1'b0}}});
    assign head     = mem[rdPtr_q[AW-1:0]];
    assign headIsLf = (NL_EXPAND != 0) && (head == CHAR_LF);
    assign push     = out_write && !full;

    assign out_ready    = !full;
    assign out_overflow = overflow_q;
    assign fill_level   = wrPtr_q - rdPtr_q;

    // An expanded LF stays at the head until its second half (the LF itself)
    // is accepted, so it keeps counting as one stored entry meanwhile.
    always_comb begin
        state_d  = state_q;
        tx_valid = 1'b0;
        tx_data  = head;
        pop      = 1'b0;
        case (state_q)
            S_DATA: begin
                tx_valid = !empty;
                if (headIsLf) begin
                    tx_data = CHAR_CR;
                    if (!empty && tx_ready) begin
                        state_d = S_LF;
                    end
                end else begin
                    pop = !empty && tx_ready;
                end
            end
            S_LF: begin
                tx_valid = 1'b1;
                tx_data  = CHAR_LF;
                if (tx_ready) begin
                    pop     = 1'b1;
                    state_d = S_DATA;
                end
            end
            default: state_d = S_DATA;
        endcase
    end

    // Fullness is judged before the edge, so a dropped write sets the flag
    // even if a pop happens on the same cycle; setting beats clearing.
    always_comb begin
        wrPtr_d    = wrPtr_q + (AW + 1)'(push);
        rdPtr_d    = rdPtr_q + (AW + 1)'(pop);
        overflow_d = overflow_q;
        if (out_write && full) begin
            overflow_d = 1'b1;
        end else if (out_clear) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state_q    <= S_DATA;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr_q[AW-1:0]] <= io_out[BYTE_WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_io_output_buffer.sv
// Randomized and directed checks of io_output_buffer, with and without LF
// expansion, against a shift-list model of the character stream.
module tb_io_output_buffer;

    localparam int DEPTH = 16;

    logic        clk;
    logic        areset;
    logic        outWrite;
    logic [15:0] ioOut;
    logic        outClear;
    logic        txReady;

    logic        rdy  [2];
    logic        ovf  [2];
    logic [4:0]  fill [2];
    logic        vld  [2];
    logic [7:0]  dat  [2];

    int total = 0;
    int bad   = 0;

    // Model: per instance, the stored bytes in arrival order, whether the CR
    // of a leading LF has already gone out, and the sticky overflow flag.
    logic [7:0] mBuf     [2][DEPTH];
    int         mCount   [2];
    bit         mSentCr  [2];
    bit         mOvf     [2];

    io_output_buffer #(.WORD_SIZE(16), .BYTE_WIDTH(8), .DEPTH(DEPTH), .NL_EXPAND(0)) dut0 (
        .clk(clk), .areset(areset), .out_write(outWrite), .io_out(ioOut),
        .out_ready(rdy[0]), .out_overflow(ovf[0]), .out_clear(outClear),
        .fill_level(fill[0]), .tx_valid(vld[0]), .tx_data(dat[0]), .tx_ready(txReady)
    );

    io_output_buffer #(.WORD_SIZE(16), .BYTE_WIDTH(8), .DEPTH(DEPTH), .NL_EXPAND(1)) dut1 (
        .clk(clk), .areset(areset), .out_write(outWrite), .io_out(ioOut),
        .out_ready(rdy[1]), .out_overflow(ovf[1]), .out_clear(outClear),
        .fill_level(fill[1]), .tx_valid(vld[1]), .tx_data(dat[1]), .tx_ready(txReady)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic resetModel();
        for (int i = 0; i < 2; i++) begin
            mCount[i]  = 0;
            mSentCr[i] = 1'b0;
            mOvf[i]    = 1'b0;
        end
    endtask

    task automatic checkAll(input string tag);
        logic [7:0] expData;
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("%s.ready%0d", tag, i), 32'(rdy[i]), 32'(mCount[i] < DEPTH));
            checkOutput($sformatf("%s.ovf%0d", tag, i), 32'(ovf[i]), 32'(mOvf[i]));
            checkOutput($sformatf("%s.fill%0d", tag, i), 32'(fill[i]), 32'(mCount[i]));
            checkOutput($sformatf("%s.valid%0d", tag, i), 32'(vld[i]), 32'(mCount[i] > 0));
            if (mCount[i] > 0) begin
                expData = mBuf[i][0];
                if (i == 1 && mBuf[i][0] == 8'h0A && !mSentCr[i]) expData = 8'h0D;
                checkOutput($sformatf("%s.data%0d", tag, i), 32'(dat[i]), 32'(expData));
            end
        end
    endtask

    task automatic updateModel(input bit w, input logic [7:0] d, input bit clr, input bit r);
        bit wasFull;
        for (int i = 0; i < 2; i++) begin
            wasFull = (mCount[i] == DEPTH);
            if (r && mCount[i] > 0) begin
                if (i == 1 && mBuf[i][0] == 8'h0A && !mSentCr[i]) begin
                    mSentCr[i] = 1'b1;
                end else begin
                    for (int k = 0; k < DEPTH - 1; k++) mBuf[i][k] = mBuf[i][k+1];
                    mCount[i]--;
                    mSentCr[i] = 1'b0;
                end
            end
            if (w) begin
                if (!wasFull) begin
                    mBuf[i][mCount[i]] = d;
                    mCount[i]++;
                end else begin
                    mOvf[i] = 1'b1;
                end
            end
            if (clr && !(w && wasFull)) mOvf[i] = 1'b0;
        end
    endtask

    // One cycle: check the state-derived outputs, drive inputs, clock, advance model.
    task automatic applyStimulus(input string tag, input bit w, input logic [7:0] d,
                                 input bit clr, input bit r);
        checkAll(tag);
        outWrite = w;
        ioOut    = {8'hA5, d};
        outClear = clr;
        txReady  = r;
        @(posedge clk);
        updateModel(w, d, clr, r);
        @(negedge clk);
    endtask

    task automatic asyncReset(input string tag);
        #2;
        areset   = 1'b0;
        outWrite = 1'b0;
        outClear = 1'b0;
        txReady  = 1'b0;
        resetModel();
        #1;
        checkAll(tag);
        @(negedge clk);
        areset = 1'b1;
    endtask

    initial begin
        logic [7:0] nlBytes [3];
        logic [7:0] rb;
        int         written;
        nlBytes[0] = 8'h48;
        nlBytes[1] = 8'h0A;
        nlBytes[2] = 8'h49;

        areset   = 1'b0;
        outWrite = 1'b0;
        ioOut    = '0;
        outClear = 1'b0;
        txReady  = 1'b0;
        resetModel();
        repeat (2) @(negedge clk);
        checkAll("reset");
        areset = 1'b1;
        @(negedge clk);

        applyStimulus("ord", 1, 8'h41, 0, 1);
        applyStimulus("ord", 1, 8'h42, 0, 1);
        applyStimulus("ord", 1, 8'h43, 0, 1);
        applyStimulus("ord", 0, 8'h00, 0, 1);
        applyStimulus("ord", 0, 8'h00, 0, 1);

        for (int k = 0; k < DEPTH + 1; k++) applyStimulus("fill", 1, 8'(8'h10 + k), 0, 0);
        applyStimulus("ovfClr", 1, 8'h99, 1, 0);
        applyStimulus("ovfHeld", 0, 8'h00, 1, 0);
        applyStimulus("ovfGone", 0, 8'h00, 0, 0);
        for (int k = 0; k < DEPTH + 4; k++) applyStimulus("drain", 0, 8'h00, 0, 1);

        for (int k = 0; k < 3; k++) applyStimulus("nl", 1, nlBytes[k], 0, (k % 2) == 0);
        for (int k = 0; k < 10; k++) applyStimulus("nlDrain", 0, 8'h00, 0, (k % 2) == 1);

        applyStimulus("midLf", 1, 8'h0A, 0, 0);
        applyStimulus("midLf", 1, 8'h33, 0, 1);
        asyncReset("asyncRst");
        applyStimulus("postRst", 1, 8'h0A, 0, 0);
        applyStimulus("postRst", 0, 8'h00, 0, 0);
        for (int k = 0; k < 4; k++) applyStimulus("postRstDrain", 0, 8'h00, 0, 1);

        written = 0;
        for (int cyc = 0; cyc < 600 && written < 3 * DEPTH; cyc++) begin
            rb = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) rb = 8'h0A;
            if ($urandom_range(0, 1) == 1) begin
                applyStimulus("rand", 1, rb, 0, $urandom_range(0, 3) != 0);
                written++;
            end else begin
                applyStimulus("rand", 0, rb, 0, $urandom_range(0, 3) != 0);
            end
        end
        checkOutput("randWritten", 32'(written), 32'(3 * DEPTH));
        for (int k = 0; k < 2 * DEPTH + 8; k++) applyStimulus("randDrain", 0, 8'h00, 0, 1);
        checkAll("final");
        asyncReset("endRst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
